// File: rtl/alu_div_iter.sv
// ============================================================================
// Module   : alu_div_iter
// Purpose  : Iterative radix-2 restoring divider with signed/unsigned and
//            32-bit word modes; one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_div_iter #(
   parameter int XLEN    = 64,
   parameter int WORD_EN = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            is_signed,
   input  logic            is_word,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            div_by_zero,
   output logic            busy
);

   localparam int WEN = (XLEN == 32) ? 0 : WORD_EN;
   localparam int CW  = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            word_q, word_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rmd_q, rmd_d;
   logic            dbz_q, dbz_d;

   logic            w_word;
   logic [XLEN-1:0] w_a_sx, w_b_sx, w_a_mag, w_b_mag, w_min;
   logic            w_a_neg, w_b_neg, w_zero, w_ovf;
   logic [XLEN:0]   w_psh, w_diff;
   logic            w_qbit;
   logic [XLEN-1:0] w_rem_nx, w_dvd_nx, w_q_fin, w_r_fin, w_q_out, w_r_out;

   // Operand preparation for a request sitting on the inputs
   assign w_word  = is_word && (WEN != 0);
   assign w_a_sx  = w_word ? XLEN'($signed(a[31:0])) : a;
   assign w_b_sx  = w_word ? XLEN'($signed(b[31:0])) : b;
   assign w_a_neg = is_signed & w_a_sx[XLEN-1];
   assign w_b_neg = is_signed & w_b_sx[XLEN-1];
   assign w_a_mag = w_a_neg ? -w_a_sx : (w_word ? XLEN'(a[31:0]) : a);
   assign w_b_mag = w_b_neg ? -w_b_sx : (w_word ? XLEN'(b[31:0]) : b);
   assign w_min   = {XLEN{1'b1}} << (w_word ? 31 : XLEN - 1);
   assign w_zero  = (w_b_sx == '0);
   assign w_ovf   = is_signed & (w_a_sx == w_min) & (&w_b_sx);

   // One shift-subtract step; word-mode dividends are pre-aligned to the MSB
   assign w_psh    = {rem_q, dvd_q[XLEN-1]};
   assign w_diff   = w_psh - {1'b0, dvs_q};
   assign w_qbit   = ~w_diff[XLEN];
   assign w_rem_nx = w_qbit ? w_diff[XLEN-1:0] : w_psh[XLEN-1:0];
   assign w_dvd_nx = {dvd_q[XLEN-2:0], w_qbit};
   assign w_q_fin  = qneg_q ? -w_dvd_nx : w_dvd_nx;
   assign w_r_fin  = rneg_q ? -w_rem_nx : w_rem_nx;
   assign w_q_out  = word_q ? XLEN'($signed(w_q_fin[31:0])) : w_q_fin;
   assign w_r_out  = word_q ? XLEN'($signed(w_r_fin[31:0])) : w_r_fin;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      word_d  = word_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (w_zero) begin
                  quo_d   = '1;
                  rmd_d   = w_a_sx;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else if (w_ovf) begin
                  quo_d   = w_a_sx;
                  rmd_d   = '0;
                  dbz_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  dvd_d   = w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
                  rem_d   = '0;
                  dvs_d   = w_b_mag;
                  cnt_d   = w_word ? CW'(32) : CW'(XLEN);
                  qneg_d  = w_a_neg ^ w_b_neg;
                  rneg_d  = w_a_neg;
                  word_d  = w_word;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            dvd_d = w_dvd_nx;
            rem_d = w_rem_nx;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               quo_d   = w_q_out;
               rmd_d   = w_r_out;
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Abort wins over everything and leaves the last result untouched
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         quo_d   = quo_q;
         rmd_d   = rmd_q;
         dbz_d   = dbz_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         word_q  <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         word_q  <= word_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_div_iter.sv
// ============================================================================
// Module   : tb_alu_div_iter
// Purpose  : Scoreboard bench for alu_div_iter against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_div_iter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic [63:0] a, b;
   logic        is_signed, is_word, flush;
   logic        out_valid, out_ready;
   logic [63:0] quotient, remainder;
   logic        div_by_zero, busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      logic        z;
      int          lat;
      int          acc;
   } exp_t;
   exp_t exp_q[$];

   alu_div_iter #(.XLEN(64), .WORD_EN(1)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed), .is_word(is_word), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Reference: plain language-level division plus the documented special cases
   task automatic model(input logic [63:0] ta, input logic [63:0] tb_, input logic ts,
                        input logic tw, output logic [63:0] q, output logic [63:0] r,
                        output logic z, output int lat);
      logic [31:0] a32, b32, q32, r32;
      a32 = ta[31:0];
      b32 = tb_[31:0];
      z   = 1'b0;
      if (tw) begin
         lat = 33;
         if (b32 == 0) begin
            q = '1; r = sx32(a32); z = 1'b1; lat = 1;
         end else if (ts && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q = sx32(a32); r = '0; lat = 1;
         end else begin
            if (ts) begin
               q32 = $signed(a32) / $signed(b32);
               r32 = $signed(a32) % $signed(b32);
            end else begin
               q32 = a32 / b32;
               r32 = a32 % b32;
            end
            q = sx32(q32); r = sx32(r32);
         end
      end else begin
         lat = 65;
         if (tb_ == 0) begin
            q = '1; r = ta; z = 1'b1; lat = 1;
         end else if (ts && ta == 64'h8000_0000_0000_0000 && tb_ == '1) begin
            q = ta; r = '0; lat = 1;
         end else if (ts) begin
            q = $signed(ta) / $signed(tb_);
            r = $signed(ta) % $signed(tb_);
         end else begin
            q = ta / tb_;
            r = ta % tb_;
         end
      end
   endtask

   // Monitor: pops on the first cycle of each result, then checks it holds
   logic        have = 1'b0;
   logic [63:0] hq, hr;
   logic        hz;
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         have = 1'b0;
      end else if (out_valid) begin
         if (!have) begin
            have = 1'b1;
            hq = quotient; hr = remainder; hz = div_by_zero;
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_valid: got out_valid=1 expected no result pending");
            end else begin
               e = exp_q.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.z});
               chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
         end else begin
            chk("hold_quotient", quotient, hq);
            chk("hold_remainder", remainder, hr);
            chk("hold_dbz", {63'b0, div_by_zero}, {63'b0, hz});
         end
      end else begin
         have = 1'b0;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'($urandom % 2);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic issue(input logic [63:0] ta, input logic [63:0] tb_, input logic ts,
                        input logic tw, input bit push);
      int   n;
      exp_t e;
      n = 0;
      while (in_ready !== 1'b1 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (in_ready !== 1'b1) begin
         n_chk++; n_fail++;
         $display("FAIL issue_timeout: in_ready got %b expected 1", in_ready);
         return;
      end
      a = ta; b = tb_; is_signed = ts; is_word = tw; in_valid = 1'b1;
      @(posedge clk);
      if (push) begin
         model(ta, tb_, ts, tw, e.q, e.r, e.z, e.lat);
         e.acc = cyc;
         exp_q.push_back(e);
      end
      #1;
      in_valid  = 1'b0;
      a         = {$urandom, $urandom};
      b         = {$urandom, $urandom};
      is_signed = 1'($urandom % 2);
      is_word   = 1'($urandom % 2);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      if (exp_q.size() != 0 || busy) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   function automatic logic [63:0] rnd_op();
      case ($urandom % 8)
         0:       return 64'h0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'hFFFF_FFFF_8000_0000;
         4:       return 64'h0000_0000_8000_0000;
         5:       return 64'($urandom % 20);
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
      a = '0; b = '0; is_signed = 1'b0; is_word = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_quotient", quotient, 64'd0);
      chk("rst_remainder", remainder, 64'd0);
      chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b1);
      issue(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b1);
      issue(64'h0000_0000_8000_0000, '1, 1'b1, 1'b1, 1'b1);
      issue(64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1);
      issue(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b1);

      // Zero divisor held in DONE while the consumer stalls
      wait_drain();
      rdy_mode = 1;
      issue(64'h1234, 64'd0, 1'b0, 1'b0, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
      rdy_mode = 2;
      wait_drain();
      chk("after_handshake_busy", {63'b0, busy}, 64'd0);

      // Flush in the middle of an iteration
      issue(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_busy", {63'b0, busy}, 64'd0);
      chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
      issue(64'd9, 64'd3, 1'b0, 1'b0, 1'b1);
      wait_drain();

      // Flush in IDLE drops a presented request
      a = 64'd50; b = 64'd5; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_busy", {63'b0, busy}, 64'd0);

      // Asynchronous reset mid-iteration clears everything at once
      issue(64'd12345, 64'd17, 1'b1, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("areset_quotient", quotient, 64'd0);
      chk("areset_remainder", remainder, 64'd0);
      chk("areset_busy", {63'b0, busy}, 64'd0);
      chk("areset_in_ready", {63'b0, in_ready}, 64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      rdy_mode = 0;
      for (int i = 0; i < 120; i++) begin
         issue(rnd_op(), rnd_op(), 1'($urandom % 2), 1'($urandom % 2), 1'b1);
      end
      wait_drain();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_div_iter.md
ALU_DIV_ITER -- requirements
Module: alu_div_iter

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; legal values 32 and 64.
REQ-002 Parameter WORD_EN, default 1, enables 32-bit word mode; SHALL be forced to 0 when XLEN=32.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  XLEN  dividend.
REQ-008 b  input  XLEN  divisor.
REQ-009 is_signed  input  1  1 = signed, 0 = unsigned.
REQ-010 is_word  input  1  1 = 32-bit word operation (ignored when WORD_EN=0).
REQ-011 flush  input  1  synchronous abort of any in-flight operation.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 quotient  output  XLEN  quotient.
REQ-015 remainder  output  XLEN  remainder.
REQ-016 div_by_zero  output  1  current result came from a zero divisor.
REQ-017 busy  output  1  state is not IDLE.

Function
REQ-018 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 Accept on rising edge with in_valid & in_ready & ~flush; a, b, is_signed, is_word SHALL be captured then; later input changes SHALL NOT affect the operation.
REQ-020 Effective width N = 32 when is_word & WORD_EN, else XLEN; operands SHALL be a[N-1:0], b[N-1:0].
REQ-021 Zero divisor (b[N-1:0]==0): IDLE->DONE, no iteration; quotient = all ones; remainder = dividend sign-extended from bit N-1 (word) or unchanged (XLEN); div_by_zero=1.
REQ-022 Signed overflow (is_signed, dividend = most-negative N-bit, divisor = -1): IDLE->DONE; quotient = dividend; remainder = 0; div_by_zero=0.
REQ-023 Otherwise IDLE->CALC; magnitudes of both operands taken when is_signed; iteration counter loaded with N.
REQ-024 CALC SHALL produce exactly one quotient bit per cycle (shift-subtract, restoring or non-restoring); after N cycles CALC->DONE.
REQ-025 Latency: accept at edge 0 -> out_valid high in cycle N+1 (special cases REQ-021/022: cycle 1); fixed, data-independent.
REQ-026 Sign fix-up: quotient negated iff is_signed and sign bits of dividend and divisor differ; remainder negated iff is_signed and dividend negative; remainder magnitude < divisor magnitude.
REQ-027 Word mode: both results SHALL be sign-extended from bit 31 to XLEN, for signed and unsigned.
REQ-028 quotient, remainder, div_by_zero SHALL be stable throughout DONE.
REQ-029 DONE->IDLE on edge with out_ready=1; out_valid held indefinitely while out_ready=0.
REQ-030 in_ready is 0 in DONE; a new request SHALL NOT be accepted in the same cycle the result is consumed.
REQ-031 flush=1 at an edge SHALL force IDLE from any state, discarding the operation; highest priority over accept and out_ready; flush in IDLE with in_valid drops the request.
REQ-032 quotient/remainder/div_by_zero SHALL hold last values outside DONE; only out_valid qualifies them.

Reset
REQ-033 reset_n=0 SHALL immediately set state IDLE, counter 0, quotient 0, remainder 0, div_by_zero 0, out_valid 0, busy 0; in_ready 1.
REQ-034 Reset asserted mid-CALC or in DONE SHALL abort without output; first accept possible on the first edge after reset_n rises.

Verification
REQ-035 XLEN=64 unsigned a=100, b=7 -> out_valid in cycle 65, quotient 14, remainder 2, div_by_zero 0.
REQ-036 Signed a=-7, b=2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD), remainder -1 (all ones).
REQ-037 Word signed a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> out_valid cycle 1, quotient 0xFFFF_FFFF_8000_0000, remainder 0.
REQ-038 Unsigned a=0x1234, b=0 -> out_valid cycle 1, quotient all ones, remainder 0x1234, div_by_zero 1; out_ready held 0 for 5 cycles -> outputs stable, then IDLE after handshake.
REQ-039 Word unsigned a=0xFFFF_FFFF, b=1 -> out_valid cycle 33, quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 0.
REQ-040 flush in CALC cycle 10 -> IDLE next cycle, no out_valid; then a=9, b=3 -> quotient 3, remainder 0; reset_n pulse mid-CALC -> all outputs 0 immediately.
